// File: rtl/mc_control_pkg.sv
// Shared state encodings, instruction constants and datapath select encodings
// for the multicycle controller.
package mc_control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_ERROR     = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SHL = 2'b11;

    localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCS_REG    = 2'b11;

    localparam logic [SEL_W-1:0] RD_RT = 2'b00;
    localparam logic [SEL_W-1:0] RD_RD = 2'b01;
    localparam logic [SEL_W-1:0] RD_RA = 2'b10;

    localparam logic [SEL_W-1:0] MTR_ALU = 2'b00;
    localparam logic [SEL_W-1:0] MTR_MEM = 2'b01;
    localparam logic [SEL_W-1:0] MTR_PC  = 2'b10;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_R,
        CLS_JR,
        CLS_BEQ,
        CLS_ADDI,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

    // fetch / done_on_rdy are the strobes later qualified by mem_ready
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             fetch;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_toreg;
        logic             done;
        logic             done_on_rdy;
        logic             err;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SHL;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RT;
                c.mem_toreg = MTR_MEM;
                c.done      = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write   = 1'b1;
                c.iord        = 1'b1;
                c.done_on_rdy = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RD;
                c.mem_toreg = MTR_ALU;
                c.done      = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RT;
                c.mem_toreg = MTR_ALU;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
                c.done          = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                c.done      = 1'b1;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RA;
                c.mem_toreg = MTR_PC;
                c.done      = 1'b1;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_REG;
                c.done      = 1'b1;
            end
            S_ERROR: c.err = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opcode_classify.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// load flag and illegal flag.
module mc_opcode_classify
    import mc_control_pkg::*;
#(
    parameter bit ENABLE_JAL_JR = 1'b1
) (
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_t cls_o,
    output logic         is_load_o,
    output logic         illegal_o
);

    always_comb begin
        cls_o     = CLS_ILLEGAL;
        is_load_o = 1'b0;
        case (opcode_i)
            OP_LW: begin
                cls_o     = CLS_MEM;
                is_load_o = 1'b1;
            end
            OP_SW:   cls_o = CLS_MEM;
            OP_RTYPE: begin
                if (funct_i == FN_JR) cls_o = ENABLE_JAL_JR ? CLS_JR : CLS_ILLEGAL;
                else                  cls_o = CLS_R;
            end
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_ADDI: cls_o = CLS_ADDI;
            OP_J:    cls_o = CLS_J;
            OP_JAL:  cls_o = ENABLE_JAL_JR ? CLS_JAL : CLS_ILLEGAL;
            default: ;
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: Moore FSM with registered strobes,
// only the fetch strobes and the store completion qualified by mem_ready.
module multicycle_control
    import mc_control_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter bit ENABLE_JAL_JR   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_toreg,
    output logic       instr_done,
    output logic       err_illegal_opcode,
    output logic [3:0] state
);

    state_t       state_q, state_d;
    ctrl_t        ctrl_q, ctrl_d;
    logic         active_q;
    logic         is_load_q, is_load_d;
    logic         rdy;
    instr_class_t cls;
    logic         cls_is_load;
    logic         cls_illegal;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_opcode_classify #(
        .ENABLE_JAL_JR(ENABLE_JAL_JR)
    ) u_classify (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (cls),
        .is_load_o(cls_is_load),
        .illegal_o(cls_illegal)
    );

    // Next state; the first edge after reset only arms the FETCH strobes
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        if (!active_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:     if (rdy) state_d = S_DECODE;
                S_DECODE: begin
                    is_load_d = cls_is_load;
                    if (cls_illegal) begin
                        state_d = S_ERROR;
                    end else begin
                        case (cls)
                            CLS_MEM:  state_d = S_MEM_ADDR;
                            CLS_R:    state_d = S_R_EXEC;
                            CLS_JR:   state_d = S_JR;
                            CLS_BEQ:  state_d = S_BRANCH;
                            CLS_ADDI: state_d = S_ADDI_EXEC;
                            CLS_J:    state_d = S_JUMP;
                            CLS_JAL:  state_d = S_JAL;
                            default:  state_d = S_ERROR;
                        endcase
                    end
                end
                S_MEM_ADDR:  state_d = is_load_q ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (rdy) state_d = S_MEM_WB;
                S_MEM_WRITE: if (rdy) state_d = S_FETCH;
                S_R_EXEC:    state_d = S_R_WB;
                S_ADDI_EXEC: state_d = S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_ADDI_WB,
                S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
                S_ERROR:     state_d = HALT_ON_ILLEGAL ? S_ERROR : S_FETCH;
                default:     state_d = S_FETCH;
            endcase
        end
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            active_q  <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            active_q  <= 1'b1;
            is_load_q <= is_load_d;
        end
    end

    assign pc_write           = ctrl_q.pc_write | (ctrl_q.fetch & rdy);
    assign ir_write           = ctrl_q.fetch & rdy;
    assign instr_done         = ctrl_q.done | (ctrl_q.done_on_rdy & rdy);
    assign pc_write_cond      = ctrl_q.pc_write_cond;
    assign iord               = ctrl_q.iord;
    assign mem_read           = ctrl_q.mem_read;
    assign mem_write          = ctrl_q.mem_write;
    assign reg_write          = ctrl_q.reg_write;
    assign alu_src_a          = ctrl_q.alu_src_a;
    assign alu_src_b          = ctrl_q.alu_src_b;
    assign alu_op             = ctrl_q.alu_op;
    assign pc_source          = ctrl_q.pc_source;
    assign reg_dst            = ctrl_q.reg_dst;
    assign mem_toreg          = ctrl_q.mem_toreg;
    assign err_illegal_opcode = ctrl_q.err;
    assign state              = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: instance A uses the
// default parameters, instance B uses no handshake, no halt and no jal/jr.
module tb_multicycle_control;
    import mc_control_pkg::*;

    typedef enum int {K_LW, K_SW, K_R, K_JR, K_BEQ, K_ADDI, K_J, K_JAL, K_ILL} kind_e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n;
    logic [5:0] a_opcode, a_funct, b_opcode, b_funct;
    logic       a_mem_ready, b_mem_ready;

    logic       a_pc_write, a_pc_write_cond, a_iord, a_mem_read, a_mem_write, a_ir_write;
    logic       a_reg_write, a_alu_src_a, a_instr_done, a_err;
    logic [1:0] a_alu_src_b, a_alu_op, a_pc_source, a_reg_dst, a_mem_toreg;
    logic [3:0] a_state;
    logic       b_pc_write, b_pc_write_cond, b_iord, b_mem_read, b_mem_write, b_ir_write;
    logic       b_reg_write, b_alu_src_a, b_instr_done, b_err;
    logic [1:0] b_alu_src_b, b_alu_op, b_pc_source, b_reg_dst, b_mem_toreg;
    logic [3:0] b_state;

    int n_pass  = 0;
    int n_total = 0;

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .HALT_ON_ILLEGAL(1'b1), .ENABLE_JAL_JR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .opcode(a_opcode), .funct(a_funct), .mem_ready(a_mem_ready),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .iord(a_iord),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .pc_source(a_pc_source), .reg_dst(a_reg_dst),
        .mem_toreg(a_mem_toreg), .instr_done(a_instr_done),
        .err_illegal_opcode(a_err), .state(a_state)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0), .HALT_ON_ILLEGAL(1'b0), .ENABLE_JAL_JR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .opcode(b_opcode), .funct(b_funct), .mem_ready(b_mem_ready),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .iord(b_iord),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .pc_source(b_pc_source), .reg_dst(b_reg_dst),
        .mem_toreg(b_mem_toreg), .instr_done(b_instr_done),
        .err_illegal_opcode(b_err), .state(b_state)
    );

    logic [23:0] obs_a, obs_b;
    assign obs_a = {a_pc_write, a_pc_write_cond, a_iord, a_mem_read, a_mem_write, a_ir_write,
                    a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op, a_pc_source, a_reg_dst,
                    a_mem_toreg, a_instr_done, a_err, a_state};
    assign obs_b = {b_pc_write, b_pc_write_cond, b_iord, b_mem_read, b_mem_write, b_ir_write,
                    b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_source, b_reg_dst,
                    b_mem_toreg, b_instr_done, b_err, b_state};

    // Expected output vector for one cycle spent in state s, from the output table
    function automatic logic [23:0] exp_vec(state_t s, logic rdy, bit hs);
        logic pcw, pcwc, iord, mr, mw, irw, rw, asa, done, err, r;
        logic [1:0] asb, aop, psrc, rdst, mtr;
        {pcw, pcwc, iord, mr, mw, irw, rw, asa, done, err} = '0;
        {asb, aop, psrc, rdst, mtr} = '0;
        r = hs ? rdy : 1'b1;
        case (s)
            S_FETCH:     begin mr = 1; asb = 2'b01; pcw = r; irw = r; end
            S_DECODE:    asb = 2'b11;
            S_MEM_ADDR,
            S_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
            S_MEM_READ:  begin mr = 1; iord = 1; end
            S_MEM_WB:    begin rw = 1; mtr = 2'b01; done = 1; end
            S_MEM_WRITE: begin mw = 1; iord = 1; done = r; end
            S_R_EXEC:    begin asa = 1; aop = 2'b10; end
            S_R_WB:      begin rw = 1; rdst = 2'b01; done = 1; end
            S_ADDI_WB:   begin rw = 1; done = 1; end
            S_BRANCH:    begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
            S_JUMP:      begin pcw = 1; psrc = 2'b10; done = 1; end
            S_JAL:       begin pcw = 1; psrc = 2'b10; rw = 1; rdst = 2'b10; mtr = 2'b10; done = 1; end
            S_JR:        begin pcw = 1; psrc = 2'b11; done = 1; end
            S_ERROR:     err = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, rw, asa, asb, aop, psrc, rdst, mtr, done, err, 4'(s)};
    endfunction

    function automatic kind_e classify(logic [5:0] op, logic [5:0] fn, bit en);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return (fn == 6'b001000) ? (en ? K_JR : K_ILL) : K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            6'b000011: return en ? K_JAL : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    // Runs one instruction on DUT A (which=0) or B (which=1) starting in FETCH,
    // comparing every cycle; wf/wm are wait cycles in fetch / memory phases
    task automatic run_instr(input bit which, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input string tag);
        state_t      ph[$];
        kind_e       k;
        bit          hs;
        logic [23:0] exp, got;
        logic        r;
        hs = (which == 1'b0);
        k  = classify(op, fn, hs);
        ph = {S_FETCH, S_DECODE};
        case (k)
            K_LW:   begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_READ); ph.push_back(S_MEM_WB); end
            K_SW:   begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_WRITE); end
            K_R:    begin ph.push_back(S_R_EXEC); ph.push_back(S_R_WB); end
            K_ADDI: begin ph.push_back(S_ADDI_EXEC); ph.push_back(S_ADDI_WB); end
            K_BEQ:  ph.push_back(S_BRANCH);
            K_J:    ph.push_back(S_JUMP);
            K_JAL:  ph.push_back(S_JAL);
            K_JR:   ph.push_back(S_JR);
            default: ph.push_back(S_ERROR);
        endcase
        foreach (ph[i]) begin
            int  n;
            bit  gated;
            gated = hs && (ph[i] == S_FETCH || ph[i] == S_MEM_READ || ph[i] == S_MEM_WRITE);
            n = !gated ? 0 : (ph[i] == S_FETCH) ? wf : wm;
            for (int c = 0; c <= n; c++) begin
                r = gated ? ((c == n) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
                if (which == 1'b0) begin
                    a_mem_ready = r;
                    a_opcode    = (ph[i] == S_DECODE) ? op : 6'($urandom);
                    a_funct     = (ph[i] == S_DECODE) ? fn : 6'($urandom);
                end else begin
                    b_mem_ready = r;
                    b_opcode    = (ph[i] == S_DECODE) ? op : 6'($urandom);
                    b_funct     = (ph[i] == S_DECODE) ? fn : 6'($urandom);
                end
                @(negedge clk);
                exp = exp_vec(ph[i], r, hs);
                got = which ? obs_b : obs_a;
                n_total++;
                if (got !== exp)
                    $display("FAIL %s op=%b phase=%0d wait=%0d got=%h expected=%h", tag, op, i, c, got, exp);
                else
                    n_pass++;
                @(posedge clk); #1;
            end
        end
        if (which == 1'b0) a_mem_ready = 1'b0;
    endtask

    // Async reset applied between edges; outputs must drop at once and stay low
    task automatic reset_dut(input bit which);
        logic [23:0] got;
        if (which == 1'b0) begin a_mem_ready = 1'b1; rst_a_n = 1'b0; end
        else               begin b_mem_ready = 1'b1; rst_b_n = 1'b0; end
        #1;
        got = which ? obs_b : obs_a;
        n_total++;
        if (got !== 24'h0) $display("FAIL rst_async dut=%0d got=%h expected=0", which, got);
        else n_pass++;
        @(posedge clk); #1;
        got = which ? obs_b : obs_a;
        n_total++;
        if (got !== 24'h0) $display("FAIL rst_hold dut=%0d got=%h expected=0", which, got);
        else n_pass++;
        @(negedge clk);
        if (which == 1'b0) begin a_mem_ready = 1'b0; rst_a_n = 1'b1; end
        else               rst_b_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_opcode = '0; a_funct = '0; b_opcode = 6'b111111; b_funct = '0;
        a_mem_ready = 1'b1; b_mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs_a !== 24'h0) $display("FAIL reset_a got=%h expected=0", obs_a); else n_pass++;
        n_total++;
        if (obs_b !== 24'h0) $display("FAIL reset_b got=%h expected=0", obs_b); else n_pass++;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (obs_a !== exp_vec(S_FETCH, 1'b1, 1'b1))
            $display("FAIL first_fetch_a got=%h expected=%h", obs_a, exp_vec(S_FETCH, 1'b1, 1'b1));
        else n_pass++;
        n_total++;
        if (obs_b !== exp_vec(S_FETCH, 1'b1, 1'b0))
            $display("FAIL first_fetch_b got=%h expected=%h", obs_b, exp_vec(S_FETCH, 1'b1, 1'b0));
        else n_pass++;
        a_mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_instr(1'b0, 6'b100011, 6'($urandom), 0, 0, "lw");
    endtask

    task automatic test_sw_wait();
        run_instr(1'b0, 6'b101011, 6'($urandom), 0, 3, "sw_wait");
    endtask

    task automatic test_fetch_wait();
        run_instr(1'b0, 6'b000000, 6'b100000, 2, 0, "fetch_wait");
    endtask

    task automatic test_jr();
        run_instr(1'b0, 6'b000000, 6'b001000, 1, 0, "jr_a");
        run_instr(1'b0, 6'b000011, 6'($urandom), 0, 0, "jal_a");
        reset_dut(1'b1);
        run_instr(1'b1, 6'b000000, 6'b001000, 0, 0, "jr_b_illegal");
        run_instr(1'b1, 6'b000011, 6'($urandom), 0, 0, "jal_b_illegal");
        run_instr(1'b1, 6'b001000, 6'($urandom), 0, 0, "addi_b");
    endtask

    task automatic test_illegal();
        run_instr(1'b0, 6'b111111, 6'($urandom), 0, 0, "ill_a");
        for (int c = 0; c < 9; c++) begin
            a_opcode    = 6'($urandom);
            a_mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_total++;
            if (obs_a !== exp_vec(S_ERROR, a_mem_ready, 1'b1))
                $display("FAIL ill_a_hold cycle=%0d got=%h expected=%h", c, obs_a, exp_vec(S_ERROR, a_mem_ready, 1'b1));
            else n_pass++;
            @(posedge clk); #1;
        end
        reset_dut(1'b0);
        reset_dut(1'b1);
        run_instr(1'b1, 6'b111111, 6'($urandom), 0, 0, "ill_b");
        run_instr(1'b1, 6'b000010, 6'($urandom), 0, 0, "after_ill_b");
    endtask

    task automatic test_reset_mid();
        a_mem_ready = 1'b1; a_opcode = '0;
        @(posedge clk); #1;
        a_opcode = 6'b100011; a_mem_ready = 1'b0;
        @(posedge clk); #1;
        a_opcode = 6'($urandom);
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (obs_a !== exp_vec(S_MEM_READ, 1'b0, 1'b1))
            $display("FAIL mid_memread got=%h expected=%h", obs_a, exp_vec(S_MEM_READ, 1'b0, 1'b1));
        else n_pass++;
        #2 rst_a_n = 1'b0;
        #1;
        n_total++;
        if (obs_a !== 24'h0) $display("FAIL mid_async got=%h expected=0", obs_a); else n_pass++;
        a_mem_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (obs_a !== 24'h0) $display("FAIL mid_hold got=%h expected=0", obs_a); else n_pass++;
        @(negedge clk) rst_a_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (obs_a !== exp_vec(S_FETCH, 1'b1, 1'b1))
            $display("FAIL mid_refetch got=%h expected=%h", obs_a, exp_vec(S_FETCH, 1'b1, 1'b1));
        else n_pass++;
        a_mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] op, fn;
        int         sel;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 7);
            op  = ops[sel];
            fn  = 6'($urandom);
            if (sel == 3) fn = 6'b001000;
            else if (sel == 2 && fn == 6'b001000) fn = 6'b100000;
            run_instr(1'b0, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), "rand_a");
        end
        reset_dut(1'b1);
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            op  = (sel > 7) ? 6'($urandom) : ops[sel];
            fn  = (sel == 3) ? 6'b001000 : 6'($urandom);
            run_instr(1'b1, op, fn, 0, 0, "rand_b");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_jr();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
